// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-driven host control for the pipelined MIPS core
// Loads instruction memory, runs or single-steps the core, and dumps PC plus registers.
module debug_unit #(
   parameter int IMEM_ADDR_W = 8
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [7:0]             RxData,
   input  logic                   RxValid,
   output logic [7:0]             TxData,
   output logic                   TxStart,
   input  logic                   TxBusy,
   output logic                   ImemWrEn,
   output logic [IMEM_ADDR_W-1:0] ImemAddr,
   output logic [31:0]            ImemWrData,
   output logic                   CpuEnable,
   output logic                   CpuReset,
   output logic [4:0]             DbgRegAddr,
   input  logic [31:0]            DbgRegData,
   input  logic [31:0]            PCResult,
   input  logic                   Halted,
   output logic [3:0]             DbgState
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      LOAD_CNT   = 4'd1,
      LOAD_BYTE  = 4'd2,
      LOAD_WRITE = 4'd3,
      RUN        = 4'd4,
      STEP       = 4'd5,
      DUMP_SEND  = 4'd6,
      DUMP_WAIT  = 4'd7,
      REPLY      = 4'd8,
      REPLY_WAIT = 4'd9
   } state_t;

   localparam logic [7:0] CMD_LOAD  = 8'h4C;
   localparam logic [7:0] CMD_RUN   = 8'h52;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [7:0] CMD_DUMP  = 8'h44;
   localparam logic [7:0] CMD_ABORT = 8'h48;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;
   localparam logic [7:0] DUMP_LAST = 8'd131;

   state_t                 state;
   logic [7:0]             wordsLeft;
   logic [IMEM_ADDR_W-1:0] wordIdx;
   logic [1:0]             byteIdx;
   logic [23:0]            shiftReg;
   logic [7:0]             dumpIdx;
   logic [23:0]            sendRest;
   logic [7:0]             replyByte;
   logic                   txGuard;
   logic [7:0]             nextDumpIdx;
   logic [5:0]             nextWordNum;
   logic [31:0]            dumpWord;

   assign DbgState    = state;
   assign nextDumpIdx = dumpIdx + 8'd1;
   assign nextWordNum = nextDumpIdx[7:2];

   // Bytes 0..3 carry the PC; every later 4-byte group is one register.
   always_comb begin
      dumpWord = DbgRegData;
      if (dumpIdx < 8'd4) dumpWord = PCResult;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         TxData     <= 8'h00;
         TxStart    <= 1'b0;
         ImemWrEn   <= 1'b0;
         ImemAddr   <= '0;
         ImemWrData <= 32'h0;
         CpuEnable  <= 1'b0;
         CpuReset   <= 1'b1;
         DbgRegAddr <= 5'd0;
         wordsLeft  <= 8'd0;
         wordIdx    <= '0;
         byteIdx    <= 2'd0;
         shiftReg   <= 24'h0;
         dumpIdx    <= 8'd0;
         sendRest   <= 24'h0;
         replyByte  <= 8'h00;
         txGuard    <= 1'b0;
      end else begin
         TxStart  <= 1'b0;
         ImemWrEn <= 1'b0;
         CpuReset <= 1'b0;
         case (state)
            IDLE: begin
               if (RxValid) begin
                  case (RxData)
                     CMD_LOAD: state <= LOAD_CNT;
                     CMD_RUN: begin
                        if (Halted) begin
                           dumpIdx    <= 8'd0;
                           DbgRegAddr <= 5'd0;
                           state      <= DUMP_SEND;
                        end else begin
                           CpuEnable <= 1'b1;
                           state     <= RUN;
                        end
                     end
                     CMD_STEP: begin
                        CpuEnable <= 1'b1;
                        state     <= STEP;
                     end
                     CMD_DUMP: begin
                        dumpIdx    <= 8'd0;
                        DbgRegAddr <= 5'd0;
                        state      <= DUMP_SEND;
                     end
                     default: begin
                        replyByte <= NAK;
                        state     <= REPLY;
                     end
                  endcase
               end
            end
            LOAD_CNT: begin
               if (RxValid) begin
                  wordsLeft <= RxData;
                  wordIdx   <= '0;
                  byteIdx   <= 2'd0;
                  if (RxData == 8'd0) begin
                     CpuReset  <= 1'b1;
                     replyByte <= ACK;
                     state     <= REPLY;
                  end else begin
                     state <= LOAD_BYTE;
                  end
               end
            end
            LOAD_BYTE: begin
               if (RxValid) begin
                  shiftReg <= {shiftReg[15:0], RxData};
                  byteIdx  <= byteIdx + 2'd1;
                  if (byteIdx == 2'd3) begin
                     ImemWrEn   <= 1'b1;
                     ImemWrData <= {shiftReg, RxData};
                     ImemAddr   <= wordIdx;
                     state      <= LOAD_WRITE;
                  end
               end
            end
            LOAD_WRITE: begin
               wordIdx   <= wordIdx + IMEM_ADDR_W'(1);
               wordsLeft <= wordsLeft - 8'd1;
               if (wordsLeft == 8'd1) begin
                  CpuReset  <= 1'b1;
                  replyByte <= ACK;
                  state     <= REPLY;
               end else begin
                  state <= LOAD_BYTE;
               end
            end
            RUN: begin
               if (Halted || (RxValid && RxData == CMD_ABORT)) begin
                  CpuEnable  <= 1'b0;
                  dumpIdx    <= 8'd0;
                  DbgRegAddr <= 5'd0;
                  state      <= DUMP_SEND;
               end
            end
            STEP: begin
               CpuEnable  <= 1'b0;
               dumpIdx    <= 8'd0;
               DbgRegAddr <= 5'd0;
               state      <= DUMP_SEND;
            end
            DUMP_SEND: begin
               if (!TxBusy) begin
                  TxStart <= 1'b1;
                  txGuard <= 1'b1;
                  state   <= DUMP_WAIT;
                  if (dumpIdx[1:0] == 2'd0) begin
                     TxData   <= dumpWord[31:24];
                     sendRest <= dumpWord[23:0];
                  end else begin
                     TxData   <= sendRest[23:16];
                     sendRest <= {sendRest[15:0], 8'h00};
                  end
               end
            end
            DUMP_WAIT: begin
               // TxBusy still reads low while TxStart is high, so skip that cycle.
               if (txGuard) begin
                  txGuard <= 1'b0;
               end else if (!TxBusy) begin
                  dumpIdx <= nextDumpIdx;
                  if (dumpIdx == DUMP_LAST) begin
                     state <= IDLE;
                  end else begin
                     if (nextDumpIdx[1:0] == 2'd0 && nextWordNum != 6'd0)
                        DbgRegAddr <= 5'(nextWordNum - 6'd1);
                     state <= DUMP_SEND;
                  end
               end
            end
            REPLY: begin
               if (!TxBusy) begin
                  TxStart <= 1'b1;
                  TxData  <= replyByte;
                  txGuard <= 1'b1;
                  state   <= REPLY_WAIT;
               end
            end
            REPLY_WAIT: begin
               if (txGuard) txGuard <= 1'b0;
               else if (!TxBusy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - scoreboard bench for debug_unit
// Models the UART transmitter and a PC/register-file core around the DUT.
module tb_debug_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  RxData = 8'h00;
   logic        RxValid = 1'b0;
   logic [7:0]  TxData;
   logic        TxStart;
   logic        TxBusy;
   logic        ImemWrEn;
   logic [7:0]  ImemAddr;
   logic [31:0] ImemWrData;
   logic        CpuEnable;
   logic        CpuReset;
   logic [4:0]  DbgRegAddr;
   logic [31:0] DbgRegData;
   logic [31:0] PCResult;
   logic        Halted;
   logic [3:0]  DbgState;

   debug_unit #(.IMEM_ADDR_W(8)) dut (
      .Clock(Clock), .Reset(Reset), .RxData(RxData), .RxValid(RxValid),
      .TxData(TxData), .TxStart(TxStart), .TxBusy(TxBusy),
      .ImemWrEn(ImemWrEn), .ImemAddr(ImemAddr), .ImemWrData(ImemWrData),
      .CpuEnable(CpuEnable), .CpuReset(CpuReset),
      .DbgRegAddr(DbgRegAddr), .DbgRegData(DbgRegData),
      .PCResult(PCResult), .Halted(Halted), .DbgState(DbgState)
   );

   always #5 Clock = ~Clock;

   logic [31:0] pcModel;
   logic [31:0] regs [32];
   int          enTotal = 0;
   int          enBase = 0;
   int          crTotal = 0;
   int          wrTotal = 0;
   int          busyCnt = 0;
   int          txDelay = 3;
   logic        haltArm = 1'b0;
   logic        haltForce = 1'b0;

   assign TxBusy     = (busyCnt != 0);
   assign PCResult   = pcModel;
   assign DbgRegData = regs[DbgRegAddr];
   assign Halted     = haltForce || (haltArm && (enTotal - enBase >= 19));

   always @(posedge Clock) begin
      if (CpuReset) pcModel <= 32'h0;
      else if (CpuEnable) pcModel <= pcModel + 32'd4;
      if (CpuEnable) enTotal <= enTotal + 1;
      if (CpuReset) crTotal <= crTotal + 1;
      if (ImemWrEn) wrTotal <= wrTotal + 1;
      if (TxStart && busyCnt == 0) busyCnt <= txDelay;
      else if (busyCnt != 0) busyCnt <= busyCnt - 1;
   end

   int          nChecks = 0;
   int          nPass = 0;
   logic [7:0]  txQ [$];
   int          txTag [$];
   logic [39:0] wrQ [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every TxStart / ImemWrEn pops the scoreboard.
   always @(negedge Clock) begin
      if (!Reset) begin
         if (TxStart) begin
            check("tx_while_busy", 64'(TxBusy), 64'(0));
            if (txQ.size() == 0) begin
               nChecks++;
               $display("FAIL tx_unexpected: got byte %0h, expected none", TxData);
            end else begin
               logic [7:0] e;
               int t;
               e = txQ.pop_front();
               t = txTag.pop_front();
               check($sformatf("tx_byte[%0d]", t), 64'(TxData), 64'(e));
            end
         end
         if (ImemWrEn) begin
            if (wrQ.size() == 0) begin
               nChecks++;
               $display("FAIL wr_unexpected: got addr %0h data %0h, expected none", ImemAddr, ImemWrData);
            end else begin
               logic [39:0] w;
               w = wrQ.pop_front();
               check("imem_write", 64'({ImemAddr, ImemWrData}), 64'(w));
            end
         end
      end
   end

   task automatic sendByte(input logic [7:0] b);
      @(posedge Clock);
      #1 RxData = b;
      RxValid = 1'b1;
      @(posedge Clock);
      #1 RxValid = 1'b0;
   endtask

   task automatic pushTx(input logic [7:0] b, input int tag);
      txQ.push_back(b);
      txTag.push_back(tag);
   endtask

   task automatic pushDump(input logic [31:0] pc);
      for (int k = 0; k < 4; k++) pushTx(pc[31-8*k -: 8], k);
      for (int r = 0; r < 32; r++)
         for (int k = 0; k < 4; k++) pushTx(regs[r][31-8*k -: 8], 4 + 4*r + k);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n;
      n = 0;
      while (!(txQ.size() == 0 && wrQ.size() == 0 && DbgState == 4'd0 && !TxBusy) && n < budget) begin
         @(posedge Clock);
         n++;
      end
      #1;
      check({name, "_complete"}, 64'(n < budget), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 32; r++)
         regs[r] = {8'(r), 8'(r + 64), 8'(r + 128), 8'(r + 192)};
      regs[0] = 32'h0;
      regs[5] = 32'hDEADBEEF;

      repeat (3) @(posedge Clock);
      #1;
      check("rst_tx", 64'({TxStart, TxData}), 64'(0));
      check("rst_imem", 64'({ImemWrEn, ImemAddr, ImemWrData}), 64'(0));
      check("rst_cpu", 64'({CpuEnable, CpuReset}), 64'(2'b01));
      check("rst_dbg", 64'({DbgRegAddr, DbgState}), 64'(0));
      Reset = 1'b0;
      @(posedge Clock);
      #1 check("rst_cpureset_drop", 64'(CpuReset), 64'(0));

      // Load two words
      wrQ.push_back({8'd0, 32'h0000000A});
      wrQ.push_back({8'd1, 32'h12345678});
      pushTx(8'h06, 0);
      begin
         int crBase;
         crBase = crTotal;
         sendByte(8'h4C); sendByte(8'h02);
         sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h0A);
         sendByte(8'h12); sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
         check("wr_latency", 64'(ImemWrEn), 64'(1));
         waitIdle("load", 500);
         check("load_cpureset_pulses", 64'(crTotal - crBase), 64'(1));
      end

      // Single step: PC 0 -> 4
      enBase = enTotal;
      pushDump(32'h00000004);
      sendByte(8'h53);
      waitIdle("step", 3000);
      check("step_en_cycles", 64'(enTotal - enBase), 64'(1));

      // Run until halt: 20 enabled cycles, PC 4 -> 0x54
      enBase = enTotal;
      haltArm = 1'b1;
      pushDump(32'h00000054);
      sendByte(8'h52);
      waitIdle("run_halt", 3000);
      haltArm = 1'b0;
      check("run_en_cycles", 64'(enTotal - enBase), 64'(20));

      // Run then abort: 11 enabled cycles, PC 0x54 -> 0x80
      enBase = enTotal;
      pushDump(32'h00000080);
      sendByte(8'h52);
      repeat (9) @(posedge Clock);
      sendByte(8'h48);
      check("abort_en_low", 64'(CpuEnable), 64'(0));
      waitIdle("run_abort", 3000);
      check("abort_en_cycles", 64'(enTotal - enBase), 64'(11));

      // Halted already set at run entry
      enBase = enTotal;
      haltForce = 1'b1;
      pushDump(32'h00000080);
      sendByte(8'h52);
      waitIdle("run_prehalted", 3000);
      haltForce = 1'b0;
      check("prehalted_en_cycles", 64'(enTotal - enBase), 64'(0));

      // Unknown command
      pushTx(8'h15, 0);
      sendByte(8'h7A);
      waitIdle("nak", 500);

      // Slow transmitter
      txDelay = 50;
      pushDump(32'h00000080);
      sendByte(8'h44);
      waitIdle("slow_dump", 9000);
      txDelay = 3;

      // Reset in the middle of a load word
      begin
         int wrBase;
         wrBase = wrTotal;
         sendByte(8'h4C); sendByte(8'h01); sendByte(8'hAA); sendByte(8'hBB);
         @(posedge Clock);
         #1 Reset = 1'b1;
         @(posedge Clock);
         #1;
         check("midrst_imem", 64'({ImemWrEn, ImemAddr, ImemWrData}), 64'(0));
         check("midrst_cpu", 64'({CpuEnable, CpuReset}), 64'(2'b01));
         check("midrst_tx", 64'({TxStart, TxData}), 64'(0));
         check("midrst_state", 64'(DbgState), 64'(0));
         Reset = 1'b0;
         repeat (4) @(posedge Clock);
         #1 check("midrst_no_write", 64'(wrTotal - wrBase), 64'(0));
      end
      pushDump(32'h00000000);
      sendByte(8'h44);
      waitIdle("post_reset_dump", 3000);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side control block for the pipelined MIPS core: consumes a byte stream from a UART receiver, loads program words into instruction memory, runs or single-steps the core via a pipeline enable, and streams PC plus register-file contents back through a UART transmitter. It sits between the UART pair and the processor top, driving the processor's enable, reset and instruction-memory write port, and reading its debug register port.

## Interface
- IMEM_ADDR_W, 8, instruction-memory word-address width
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- RxData  in  8  received byte
- RxValid  in  1  one-cycle strobe, RxData valid
- TxData  out  8  byte to transmit
- TxStart  out  1  one-cycle pulse, launches TxData
- TxBusy  in  1  transmitter busy; rises the cycle after TxStart
- ImemWrEn  out  1  one-cycle instruction-memory write strobe
- ImemAddr  out  IMEM_ADDR_W  word address for write
- ImemWrData  out  32  word to write
- CpuEnable  out  1  pipeline advance enable (PC and all stage registers)
- CpuReset  out  1  processor reset
- DbgRegAddr  out  5  register-file debug read address
- DbgRegData  in  32  combinational read data for DbgRegAddr
- PCResult  in  32  current PC
- Halted  in  1  halt instruction has reached WB
- DbgState  out  4  current FSM state encoding

## Operation
- Commands are single bytes, accepted only in IDLE: 0x4C load, 0x52 run, 0x53 step, 0x44 dump. Any other byte: send NAK 0x15, return to IDLE.
- Load: next byte N = word count; then 4N bytes, big-endian per word. After each 4th byte: ImemWrData = assembled word, ImemAddr = word index (0..N-1), ImemWrEn pulses once. After last write: CpuReset high one cycle, then send ACK 0x06. N = 0: no writes, CpuReset pulse, ACK.
- Run: CpuEnable held high until Halted = 1 or RxValid with RxData = 0x48 (abort); then CpuEnable low and dump. Halted already 1 at entry: CpuEnable never asserted, dump immediately. Other bytes during run ignored.
- Step: CpuEnable high for exactly one cycle, then dump.
- Dump: 132 bytes: PCResult [31:24], [23:16], [15:8], [7:0], then registers 0..31, each MSB byte first. DbgRegAddr = register being sent; word sampled when its first byte launches.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_SEND, DUMP_WAIT, REPLY, REPLY_WAIT.
- RxValid outside IDLE/LOAD_CNT/LOAD_BYTE/RUN is dropped.
- ImemAddr arithmetic modulo 2^IMEM_ADDR_W; N > 2^IMEM_ADDR_W wraps and overwrites low addresses.

## Timing
- Reset values: TxStart 0, TxData 0, ImemWrEn 0, ImemAddr 0, ImemWrData 0, CpuEnable 0, CpuReset 1, DbgRegAddr 0, DbgState IDLE. CpuReset drops to 0 the cycle after Reset deasserts.
- Reset mid-operation: all state abandoned in one cycle, partial word discarded, no further writes or transmits.
- ImemWrEn asserted the cycle after the RxValid carrying a word's 4th byte.
- TxStart: pulsed only when TxBusy = 0. TxBusy ignored the cycle after TxStart; next TxStart no earlier than the first cycle TxBusy is sampled 0 after that.
- Run/step to dump: first TxStart no earlier than 1 cycle after CpuEnable falls; PC sent is post-step value.
- Halted and abort byte in the same cycle: treated as one stop, single dump.
- Step: CpuEnable is 1 in exactly one cycle per 0x53 command.

## Test plan
- Load 0x4C, 0x02, 00 00 00 0A, 12 34 56 78 -> ImemWrEn pulses at addr 0 data 0x0000000A, then addr 1 data 0x12345678; CpuReset one-cycle pulse; TxData 0x06.
- Step 0x53 with PCResult advancing 0x00 to 0x04 -> CpuEnable high 1 cycle; 132 bytes sent, first four 00 00 00 04.
- Run 0x52, Halted raised after 20 cycles -> CpuEnable high exactly 20 cycles, then 132-byte dump; register 5 = 0xDEADBEEF sent as DE AD BE EF at byte offsets 24..27.
- Run then 0x48 before Halted -> CpuEnable low the cycle after abort RxValid; dump follows; unknown byte 0x7A in IDLE -> 0x15.
- TxBusy held high 50 cycles per byte -> no TxStart while busy, no dropped or duplicated dump bytes.
- Reset asserted after 2 of 4 bytes of a load word -> no ImemWrEn, all outputs at reset values, next 0x44 dumps normally.
